// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage byte-serial memory access controller.
//   - Size encodings (same as the data memory's memread/memwrite codes).
//   - FSM state type.
//   - byte_count(): bytes transferred for a given size code (0 for illegal).
package mem_access_pkg;

  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_HALF = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_t;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_WORD: return 3'd4;
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load result extension.
//   acc         in  32  assembled load bytes, last byte in [7:0]
//   size        in  2   size code (SZ_WORD / SZ_BYTE / SZ_HALF)
//   is_unsigned in  1   zero-extend instead of sign-extend
//   result      out 32  extended load value
module mem_load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  always_comb begin
    result = acc;
    case (size)
      SZ_BYTE: result = {{24{acc[7] & ~is_unsigned}}, acc[7:0]};
      SZ_HALF: result = {{16{acc[15] & ~is_unsigned}}, acc[15:0]};
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator driving a byte-wide data memory, one byte
// per cycle, most significant byte at the lowest address.
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (accept when both high)
//   req_write/size/unsigned    request attributes
//   req_addr, req_wdata        byte address, right-aligned store data
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata, rsp_err         load result / error flag, held until next response
//   busy                       high whenever not IDLE (pipeline stall)
//   mem_addr/re/we/wdata       byte memory port (outputs registered)
//   mem_rdata                  read byte, valid the cycle after mem_re
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [1:0]        cnt;
  logic [31:0]       acc;
  logic              re_q;

  logic              accept;
  logic              req_legal;
  logic [ADDR_W:0]   req_end;
  logic [2:0]        req_n;
  logic [2:0]        n_q;
  logic              last_byte;
  logic [1:0]        next_k;
  logic [31:0]       acc_next;
  logic [31:0]       load_result;

  // Byte k of an N-byte store is the (N-1-k)-th byte of the right-aligned data.
  function automatic logic [7:0] store_byte(input logic [31:0] d,
                                            input logic [2:0]  n,
                                            input logic [1:0]  k);
    logic [1:0] idx;
    idx = 2'(n - 3'd1 - {1'b0, k});
    return d[{idx, 3'b000} +: 8];
  endfunction

  assign req_ready = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign req_n     = byte_count(req_size);
  assign n_q       = byte_count(size_q);
  assign last_byte = ({1'b0, cnt} == (n_q - 3'd1));
  assign next_k    = cnt + 2'd1;

  // One extra bit so addr + N cannot wrap past the top of the address space.
  assign req_end = {1'b0, req_addr} + (ADDR_W+1)'(req_n);

  always_comb begin
    req_legal = 1'b1;
    if (req_size == 2'b00)
      req_legal = 1'b0;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
      req_legal = 1'b0;
    if ((req_size == SZ_HALF) && req_addr[0])
      req_legal = 1'b0;
    if (req_end > (ADDR_W+1)'(MEM_BYTES))
      req_legal = 1'b0;
  end

  // Read data arrives one cycle after its strobe; re_q marks those cycles.
  assign acc_next = re_q ? {acc[23:0], mem_rdata} : acc;

  mem_load_extend u_extend (
    .acc         (acc_next),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (load_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
      acc       <= '0;
      re_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      re_q      <= mem_re;
      acc       <= acc_next;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            write_q <= req_write;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            cnt     <= '0;
            acc     <= '0;
            if (req_legal) begin
              state     <= ISSUE;
              mem_addr  <= req_addr;
              mem_re    <= ~req_write;
              mem_we    <= req_write;
              mem_wdata <= req_write ? store_byte(req_wdata, req_n, 2'd0) : '0;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ISSUE: begin
          if (last_byte) begin
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            if (write_q) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt       <= next_k;
            mem_addr  <= addr_q + ADDR_W'(next_k);
            mem_wdata <= write_q ? store_byte(wdata_q, n_q, next_k) : '0;
          end
        end
        DRAIN: begin
          // Final byte lands this cycle; extend the accumulator including it.
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= load_result;
        end
        RESP: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver computes expected strobes
// and responses from a byte-array memory model and queues them; monitors on
// the falling edge pop and compare whenever the DUT strobes or responds.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned MEM_BYTES = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory seen by the DUT, and the bench's own reference copy.
  logic [7:0] mem [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  always @(posedge clk) begin
    if (mem_re)
      mem_rdata <= (mem_addr < MEM_BYTES) ? mem[mem_addr] : 8'h00;
    if (mem_we && (mem_addr < MEM_BYTES))
      mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [7:0]  data;
  } strobe_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  strobe_t exp_strobes[$];
  rsp_t    exp_rsps[$];

  int compared = 0;
  int mismatched = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: strobes and responses are compared against queued expectations.
  initial begin : monitor
    strobe_t s;
    rsp_t    r;
    forever begin
      @(negedge clk);
      if (mem_re || mem_we) begin
        if (exp_strobes.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_strobe: re=%0b we=%0b addr=0x%08h at cycle %0d, none expected",
                   mem_re, mem_we, mem_addr, cyc);
        end else begin
          s = exp_strobes.pop_front();
          check32("strobe_cycle", cyc, s.cyc);
          check32("strobe_addr", mem_addr, s.addr);
          check32("strobe_we", {31'b0, mem_we}, {31'b0, s.we});
          check32("strobe_re", {31'b0, mem_re}, {31'b0, ~s.we});
          if (s.we) check32("strobe_wdata", {24'b0, mem_wdata}, {24'b0, s.data});
        end
      end else begin
        check32("idle_mem_addr", mem_addr, 32'h0);
        check32("idle_mem_wdata", {24'b0, mem_wdata}, 32'h0);
      end
      if (rsp_valid) begin
        if (exp_rsps.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_rsp: rsp_valid at cycle %0d, none expected", cyc);
        end else begin
          r = exp_rsps.pop_front();
          check32("rsp_cycle", cyc, r.cyc);
          check32("rsp_rdata", rsp_rdata, r.rdata);
          check32("rsp_err", {31'b0, rsp_err}, {31'b0, r.err});
        end
      end
      if (rst_n)
        check32("busy_is_not_ready", {31'b0, busy}, {31'b0, ~req_ready});
    end
  end

  // Issue one request and queue its expected effects. abort: pull reset
  // during the third cycle after acceptance (word store assumed).
  task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit abort);
    int t;
    int n;
    int waited;
    bit legal;
    longint unsigned v;
    logic [7:0] b;
    strobe_t s;
    rsp_t r;

    @(posedge clk); #1;
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    waited = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waited++;
      if (waited > 50) begin
        compared++;
        mismatched++;
        $display("FAIL accept_timeout: req_ready never rose within 50 cycles");
        req_valid = 1'b0;
        return;
      end
    end
    t = cyc;

    n = (sz == 2'b01) ? 4 : (sz == 2'b10) ? 1 : (sz == 2'b11) ? 2 : 0;
    legal = (n != 0) && !(n == 4 && addr % 4 != 0) && !(n == 2 && addr % 2 != 0)
            && (longint'({32'b0, addr}) + n <= MEM_BYTES);

    if (!legal) begin
      r.cyc = t + 1; r.rdata = '0; r.err = 1'b1;
      exp_rsps.push_back(r);
    end else if (wr) begin
      for (int k = 0; k < n; k++) begin
        if (abort && k >= 2) break;
        b = 8'((wdata >> (8 * (n - 1 - k))) & 32'hFF);
        ref_mem[addr + k] = b;
        s.cyc = t + 1 + k; s.addr = addr + k; s.we = 1'b1; s.data = b;
        exp_strobes.push_back(s);
      end
      if (!abort) begin
        r.cyc = t + n + 1; r.rdata = '0; r.err = 1'b0;
        exp_rsps.push_back(r);
      end
    end else begin
      v = 0;
      for (int k = 0; k < n; k++) begin
        v = v * 256 + ref_mem[addr + k];
        s.cyc = t + 1 + k; s.addr = addr + k; s.we = 1'b0; s.data = '0;
        exp_strobes.push_back(s);
      end
      if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1)))
        v = v + (64'h1_0000_0000 - (64'd1 << (8 * n)));
      r.cyc = t + n + 2; r.rdata = v[31:0]; r.err = 1'b0;
      exp_rsps.push_back(r);
    end

    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 2'($urandom_range(0, 3));
    req_write    = 1'($urandom_range(0, 1));
    req_unsigned = 1'($urandom_range(0, 1));

    if (abort) begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check32("ready_in_reset", {31'b0, req_ready}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check32("ready_after_release", {31'b0, req_ready}, 32'h1);
      check32("busy_after_abort", {31'b0, busy}, 32'h0);
      check32("rdata_after_abort", rsp_rdata, 32'h0);
    end
  endtask

  initial begin : stim
    logic [31:0] a;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i] = 8'($urandom);
    end
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78; mem[8] = 8'h80;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = mem[i];

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_req_ready", {31'b0, req_ready}, 32'h0);
    check32("reset_busy", {31'b0, busy}, 32'h0);
    check32("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check32("reset_rsp_rdata", rsp_rdata, 32'h0);
    check32("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    check32("reset_mem_strobes", {30'b0, mem_re, mem_we}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check32("ready_first_cycle", {31'b0, req_ready}, 32'h1);

    issue(1'b0, 2'b01, 1'b0, 32'd0,  32'h0, 1'b0);         // word load 0
    issue(1'b0, 2'b10, 1'b0, 32'd8,  32'h0, 1'b0);         // byte load, signed
    issue(1'b0, 2'b10, 1'b1, 32'd8,  32'h0, 1'b0);         // byte load, unsigned
    issue(1'b1, 2'b11, 1'b0, 32'd4,  32'hDEADBEEF, 1'b0);  // half store
    issue(1'b0, 2'b11, 1'b0, 32'd4,  32'h0, 1'b0);         // half load, signed
    issue(1'b0, 2'b01, 1'b0, 32'd2,  32'h0, 1'b0);         // misaligned word
    issue(1'b0, 2'b01, 1'b0, 32'd40, 32'h0, 1'b0);         // out of bounds
    issue(1'b0, 2'b00, 1'b0, 32'd0,  32'h0, 1'b0);         // illegal size
    issue(1'b0, 2'b01, 1'b0, 32'd36, 32'h0, 1'b0);         // last legal word
    issue(1'b0, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0);  // wrap-around bound
    issue(1'b1, 2'b01, 1'b0, 32'd0,  32'hAABBCCDD, 1'b1);  // store aborted by reset
    issue(1'b0, 2'b01, 1'b0, 32'd0,  32'h0, 1'b0);         // sees partial store

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else
        a = 32'($urandom_range(0, 44));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, 1'b0);
    end

    for (int i = 0; i < 100 && (exp_rsps.size() != 0 || exp_strobes.size() != 0); i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    check32("pending_responses", 32'(exp_rsps.size()), 32'h0);
    check32("pending_strobes", 32'(exp_strobes.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
